// File: rtl/uart_tx_ctrl_if.sv
// Purpose: request/status bundle between a frame source and uart_tx_ctrl.
// Latency: n/a (wires only).
// Backpressure: none here; the source watches busy and re-presents Data_Valid itself.
// Ports: P_DATA/Data_Valid/PAR_EN/PAR_TYP from the source;
//        mux_sel/ser_data/par_bit/busy from the controller to the TX line mux.
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [2:0]            mux_sel;
  logic                  ser_data;
  logic                  par_bit;
  logic                  busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  mux_sel, ser_data, par_bit, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output mux_sel, ser_data, par_bit, busy
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// Purpose: UART transmit sequencer: START, DATA_WIDTH payload bits LSB first, optional parity, STOP.
// Latency: frame enters START on the accepting edge; DATA_WIDTH+2 cycles (+1 with parity) busy.
// Backpressure: Data_Valid is taken only in IDLE or STOP; requests at other times are dropped.
// Ports: CLK, RST (sync, active-low), bus (slave modport): payload/controls in,
//        mux_sel/ser_data/par_bit/busy out, all decoded from registered state.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_ctrl_if.slave  bus
);

  // Counter only has to reach DATA_WIDTH-1; keep at least one bit for DATA_WIDTH = 1.
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  // Encodings chosen equal to the line-mux codes.
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b011,
    PARITY = 3'b010,
    STOP   = 3'b110
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_x_q, par_x_d;   // XOR of the latched payload
  logic                  accept;
  logic [2:0]            mux_sel;
  logic                  busy;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_x_d   = par_x_q;
    accept    = 1'b0;

    case (state_q)
      IDLE:   accept = bus.Data_Valid;
      START:  state_d = DATA;
      DATA: begin
        shift_d = shift_q >> 1;
        if (cnt_q == LAST_BIT) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: state_d = STOP;
      STOP: begin
        state_d = IDLE;
        accept  = bus.Data_Valid;
      end
      default: state_d = IDLE;
    endcase

    // Acceptance is the only place the request inputs are sampled.
    if (accept) begin
      state_d   = START;
      shift_d   = bus.P_DATA;
      cnt_d     = '0;
      par_en_d  = bus.PAR_EN;
      par_typ_d = bus.PAR_TYP;
      par_x_d   = ^bus.P_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_x_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_x_q   <= par_x_d;
    end
  end

  always_comb begin
    mux_sel = 3'b000;
    busy    = 1'b0;
    case (state_q)
      IDLE:    begin mux_sel = 3'b000; busy = 1'b0; end
      START:   begin mux_sel = 3'b001; busy = 1'b1; end
      DATA:    begin mux_sel = 3'b011; busy = 1'b1; end
      PARITY:  begin mux_sel = 3'b010; busy = 1'b1; end
      STOP:    begin mux_sel = 3'b110; busy = 1'b1; end
      default: begin mux_sel = 3'b000; busy = 1'b0; end
    endcase
  end

  assign bus.mux_sel  = mux_sel;
  assign bus.busy     = busy;
  assign bus.ser_data = (state_q == DATA) & shift_q[0];
  // Odd parity is the complement of the even (plain XOR) parity.
  assign bus.par_bit  = par_x_q ^ par_typ_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

  localparam int DW = 8;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  uart_tx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of the per-cycle line outputs still owed by
  // the frame in flight. An empty queue means idle.
  typedef struct packed {
    logic [2:0] mux;
    logic       ser;
  } cyc_t;

  cyc_t exp_q[$];
  logic exp_par = 1'b0;
  bit   chk_en  = 1'b0;

  always @(posedge CLK) begin
    if (!RST) begin
      exp_q.delete();
      exp_par = 1'b0;
      chk_en  = 1'b1;
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      // Nothing left after this edge: we were idle or on the final STOP cycle.
      if (exp_q.size() == 0 && bus.Data_Valid === 1'b1) begin
        logic [DW-1:0] d;
        d = bus.P_DATA;
        exp_q.push_back('{mux: 3'b001, ser: 1'b0});
        for (int i = 0; i < DW; i++) exp_q.push_back('{mux: 3'b011, ser: d[i]});
        if (bus.PAR_EN) exp_q.push_back('{mux: 3'b010, ser: 1'b0});
        exp_q.push_back('{mux: 3'b110, ser: 1'b0});
        exp_par = (^d) ^ bus.PAR_TYP;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      cyc_t cur;
      cur = (exp_q.size() > 0) ? exp_q[0] : '0;
      check("mux_sel",  32'(bus.mux_sel),  32'(cur.mux));
      check("busy",     32'(bus.busy),     32'(exp_q.size() > 0));
      check("ser_data", 32'(bus.ser_data), 32'(cur.ser));
      check("par_bit",  32'(bus.par_bit),  32'(exp_par));
    end
  end

  // Trace of one frame, sampled from the START cycle onward.
  logic [2:0] tr_mux [0:15];
  logic       tr_ser [0:15];
  logic       tr_par;
  int         tr_busy;

  task automatic run_frame(input logic [DW-1:0] d, input logic en, input logic typ);
    @(negedge CLK);
    bus.P_DATA = d; bus.PAR_EN = en; bus.PAR_TYP = typ; bus.Data_Valid = 1'b1;
    @(negedge CLK);
    // Disturb the inputs right after acceptance; the frame must not notice.
    bus.Data_Valid = 1'b0; bus.P_DATA = ~d; bus.PAR_EN = ~en; bus.PAR_TYP = ~typ;
    tr_busy = 0;
    tr_par  = bus.par_bit;
    for (int i = 0; i < 16; i++) begin
      tr_mux[i] = bus.mux_sel;
      tr_ser[i] = bus.ser_data;
      if (bus.busy) tr_busy++;
      if (i < 15) @(negedge CLK);
    end
  endtask

  logic [2:0] a5_mux [0:11];
  logic       a5_ser [0:11];
  logic [2:0] ff_mux [0:10];

  initial begin
    int b2b;
    logic [2:0] prev;

    a5_mux = '{3'b001, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011,
               3'b011, 3'b010, 3'b110, 3'b000};
    a5_ser = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    ff_mux = '{3'b001, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011,
               3'b011, 3'b110, 3'b000};

    RST = 1'b0;
    bus.Data_Valid = 1'b0; bus.P_DATA = '0; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_par_bit", 32'(bus.par_bit), 32'h0);
    check("rst_ser",     32'(bus.ser_data), 32'h0);
    RST = 1'b1;

    // Idle hold.
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("idle_mux",  32'(bus.mux_sel), 32'h0);
      check("idle_busy", 32'(bus.busy),    32'h0);
    end

    // 0xA5, even parity.
    run_frame(8'hA5, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      check("a5_mux", 32'(tr_mux[i]), 32'(a5_mux[i]));
      check("a5_ser", 32'(tr_ser[i]), 32'(a5_ser[i]));
    end
    check("a5_par",  32'(tr_par),  32'h0);
    check("a5_busy", 32'(tr_busy), 32'd11);

    // Single set bit: odd -> 0, even -> 1.
    run_frame(8'h01, 1'b1, 1'b1);
    check("p01_odd", 32'(tr_par), 32'h0);
    run_frame(8'h01, 1'b1, 1'b0);
    check("p01_even", 32'(tr_par), 32'h1);

    // No parity, all ones.
    run_frame(8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) check("ff_mux", 32'(tr_mux[i]), 32'(ff_mux[i]));
    check("ff_busy", 32'(tr_busy), 32'd10);

    // Data_Valid held high with changing payload.
    b2b  = 0;
    prev = 3'b000;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (prev == 3'b110 && bus.mux_sel == 3'b001) b2b++;
      prev = bus.mux_sel;
      bus.Data_Valid = 1'b1;
      bus.P_DATA  = DW'($urandom);
      bus.PAR_EN  = 1'($urandom);
      bus.PAR_TYP = 1'($urandom);
    end
    check("b2b_seen", 32'(b2b >= 4), 32'h1);
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    repeat (14) @(negedge CLK);

    // Reset in the 4th DATA cycle.
    @(negedge CLK);
    bus.P_DATA = 8'h3C; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0; bus.Data_Valid = 1'b1;
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    repeat (4) @(negedge CLK);
    check("mid_data_mux", 32'(bus.mux_sel), 32'b011);
    RST = 1'b0; bus.Data_Valid = 1'b1;
    @(negedge CLK);
    check("abort_mux",  32'(bus.mux_sel), 32'h0);
    check("abort_busy", 32'(bus.busy),    32'h0);
    check("abort_par",  32'(bus.par_bit), 32'h0);
    RST = 1'b1; bus.Data_Valid = 1'b0;
    run_frame(8'h96, 1'b1, 1'b1);
    check("clean_start", 32'(tr_mux[0]), 32'b001);
    check("clean_par",   32'(tr_par),    32'h1);
    check("clean_busy",  32'(tr_busy),   32'd11);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK);
      bus.Data_Valid = ($urandom_range(0, 3) == 0);
      bus.P_DATA     = DW'($urandom);
      bus.PAR_EN     = 1'($urandom);
      bus.PAR_TYP    = 1'($urandom);
      RST            = ($urandom_range(0, 199) != 0);
    end
    @(negedge CLK);
    RST = 1'b1; bus.Data_Valid = 1'b0;
    repeat (15) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
